// File: rtl/decim_avg.sv
// Block-averaging decimator: emits one rounded mean per 2^LOG2_RATIO valid samples
// through a one-entry valid/ready output register with a sticky overrun flag.
//
// state | meaning
// EMPTY | no unaccepted result, valid_o=0
// FULL  | data_o holds a result not yet accepted, valid_o=1
module decim_avg #(
    parameter int WIDTH      = 16,
    parameter int LOG2_RATIO = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             overrun_o
);

    localparam int AW    = WIDTH + LOG2_RATIO;
    localparam int CW    = (LOG2_RATIO > 0) ? LOG2_RATIO : 1;
    localparam int RATIO = 1 << LOG2_RATIO;
    localparam int RND   = (1 << LOG2_RATIO) >> 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic signed [AW-1:0] acc_q;
    logic [CW-1:0]        cnt_q;
    logic signed [AW-1:0] data_ext;
    logic signed [AW-1:0] acc_sum;
    logic signed [AW:0]   rnd_sum;
    logic [WIDTH-1:0]     result_w;
    logic                 last_w;
    logic                 result_en;

    assign data_ext  = AW'($signed(data_i));
    assign acc_sum   = acc_q + data_ext;
    // One extra bit keeps the rounding add clear of overflow at full scale.
    assign rnd_sum   = (AW+1)'(acc_q) + (AW+1)'(data_ext) + (AW+1)'(RND);
    assign result_w  = WIDTH'(rnd_sum >>> LOG2_RATIO);
    assign last_w    = (cnt_q == CW'(RATIO - 1));
    assign result_en = valid_i && last_w && !clear_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (clear_i) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (valid_i) begin
            if (last_w) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else begin
                acc_q <= acc_sum;
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = EMPTY;
        end else if (result_en) begin
            state_d = FULL;
        end else if (state_q == FULL && ready_i) begin
            state_d = EMPTY;
        end
    end

    always_comb begin
        valid_o = (state_q == FULL);
    end

    // A result arriving while FULL and not accepted replaces the old one.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_o    <= '0;
            overrun_o <= 1'b0;
        end else begin
            if (result_en) begin
                data_o <= result_w;
            end
            if (clear_i) begin
                overrun_o <= 1'b0;
            end else if (result_en && state_q == FULL && !ready_i) begin
                overrun_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decim_avg.sv
// Self-checking bench for decim_avg: directed scenarios plus randomized traffic
// compared against a queue-based block-mean model.
module tb_decim_avg;

    localparam int R = 8;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [15:0] data_i;
    logic        valid_i;
    logic        clear_i;
    logic [15:0] data_o;
    logic        valid_o;
    logic        ready_i;
    logic        overrun_o;

    int n_checks = 0;
    int n_pass   = 0;

    int blk[$];
    int exp_data;
    bit exp_valid;
    bit exp_ovr;

    decim_avg #(.WIDTH(16), .LOG2_RATIO(3)) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .data_i   (data_i),
        .valid_i  (valid_i),
        .clear_i  (clear_i),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .overrun_o(overrun_o)
    );

    always #5 clk_i = ~clk_i;

    // Mean rounded half toward +inf, using floor division.
    function automatic int block_mean(input int s);
        int n;
        n = s + R / 2;
        if (n >= 0) return n / R;
        return -((-n + R - 1) / R);
    endfunction

    function automatic void model_reset();
        blk.delete();
        exp_data  = 0;
        exp_valid = 0;
        exp_ovr   = 0;
    endfunction

    function automatic void model_step(input bit v, input int d, input bit r, input bit c);
        int s;
        bit got;
        if (c) begin
            blk.delete();
            exp_valid = 0;
            exp_ovr   = 0;
            return;
        end
        got = 0;
        if (v) begin
            blk.push_back(d);
            if (blk.size() == R) begin
                s = 0;
                foreach (blk[i]) s += blk[i];
                blk.delete();
                got = 1;
            end
        end
        if (got) begin
            if (exp_valid && !r) exp_ovr = 1;
            exp_data  = block_mean(s);
            exp_valid = 1;
        end else if (exp_valid && r) begin
            exp_valid = 0;
        end
    endfunction

    task automatic cycle(input bit v, input int d, input bit r, input bit c);
        valid_i = v;
        data_i  = 16'(d);
        ready_i = r;
        clear_i = c;
        @(posedge clk_i);
        model_step(v, d, r, c);
        #1;
    endtask

    function automatic int dout();
        return int'($signed(data_o));
    endfunction

    task automatic test_reset();
        reset_i = 1'b1;
        valid_i = 1'b0;
        data_i  = '0;
        ready_i = 1'b0;
        clear_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        n_checks++;
        if (data_o !== 16'd0) $display("FAIL reset_data got=%0d want=0", dout()); else n_pass++;
        n_checks++;
        if (valid_o !== 1'b0) $display("FAIL reset_valid got=%b want=0", valid_o); else n_pass++;
        n_checks++;
        if (overrun_o !== 1'b0) $display("FAIL reset_ovr got=%b want=0", overrun_o); else n_pass++;
        reset_i = 1'b0;
        #1;
    endtask

    task automatic test_constant();
        for (int i = 0; i < R; i++) cycle(1, 100, 1, 0);
        n_checks++;
        if (valid_o !== 1'b1 || dout() !== 100)
            $display("FAIL const100 got=%0d/v%b want=100/v1", dout(), valid_o); else n_pass++;
        n_checks++;
        if (overrun_o !== 1'b0) $display("FAIL const100_ovr got=%b want=0", overrun_o); else n_pass++;
        cycle(0, 0, 1, 0);
        n_checks++;
        if (valid_o !== 1'b0) $display("FAIL const100_one_cycle got=%b want=0", valid_o); else n_pass++;
    endtask

    task automatic test_rounding();
        for (int i = 1; i <= R; i++) cycle(1, i, 1, 0);
        n_checks++;
        if (valid_o !== 1'b1 || dout() !== 5)
            $display("FAIL round_pos got=%0d/v%b want=5/v1", dout(), valid_o); else n_pass++;
        for (int i = 1; i <= R; i++) cycle(1, -i, 1, 0);
        n_checks++;
        if (valid_o !== 1'b1 || dout() !== -4)
            $display("FAIL round_neg got=%0d/v%b want=-4/v1", dout(), valid_o); else n_pass++;
        cycle(0, 0, 1, 0);
    endtask

    task automatic test_full_scale();
        for (int i = 0; i < R; i++) cycle(1, 32767, 1, 0);
        n_checks++;
        if (dout() !== 32767) $display("FAIL fs_max got=%0d want=32767", dout()); else n_pass++;
        for (int i = 0; i < R; i++) cycle(1, -32768, 1, 0);
        n_checks++;
        if (dout() !== -32768) $display("FAIL fs_min got=%0d want=-32768", dout()); else n_pass++;
        cycle(0, 0, 1, 0);
    endtask

    task automatic test_gaps();
        int nv;
        nv = 0;
        while (nv < R) begin
            cycle(1, 7, 1, 0);
            nv++;
            if (nv < R) begin
                n_checks++;
                if (valid_o !== 1'b0) $display("FAIL gap_early got=%b want=0 after %0d", valid_o, nv); else n_pass++;
                repeat (2) begin
                    cycle(0, 12345, 1, 0);
                    n_checks++;
                    if (valid_o !== 1'b0) $display("FAIL gap_hold got=%b want=0", valid_o); else n_pass++;
                end
            end
        end
        n_checks++;
        if (valid_o !== 1'b1 || dout() !== 7)
            $display("FAIL gap_result got=%0d/v%b want=7/v1", dout(), valid_o); else n_pass++;
        cycle(0, 0, 1, 0);
    endtask

    task automatic test_overrun();
        for (int i = 0; i < R; i++) cycle(1, 10, 0, 0);
        for (int i = 0; i < R; i++) cycle(1, 20, 0, 0);
        n_checks++;
        if (dout() !== 20 || valid_o !== 1'b1 || overrun_o !== 1'b1)
            $display("FAIL ovr_set got=%0d/v%b/o%b want=20/v1/o1", dout(), valid_o, overrun_o); else n_pass++;
        cycle(0, 0, 1, 0);
        n_checks++;
        if (valid_o !== 1'b0 || overrun_o !== 1'b1)
            $display("FAIL ovr_sticky got=v%b/o%b want=v0/o1", valid_o, overrun_o); else n_pass++;
        cycle(0, 0, 0, 1);
        n_checks++;
        if (overrun_o !== 1'b0) $display("FAIL ovr_clear got=%b want=0", overrun_o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < R; i++) cycle(1, 40, 0, 0);
        for (int i = 0; i < R - 1; i++) cycle(1, -40, 0, 0);
        cycle(1, -40, 1, 0);
        n_checks++;
        if (dout() !== -40 || valid_o !== 1'b1 || overrun_o !== 1'b0)
            $display("FAIL b2b got=%0d/v%b/o%b want=-40/v1/o0", dout(), valid_o, overrun_o); else n_pass++;
        cycle(0, 0, 1, 0);
        n_checks++;
        if (valid_o !== 1'b0) $display("FAIL b2b_drain got=%b want=0", valid_o); else n_pass++;
    endtask

    task automatic test_reset_mid_block();
        for (int i = 0; i < R; i++) cycle(1, 9, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 50, 0, 0);
        #2 reset_i = 1'b1;
        #1;
        n_checks++;
        if (valid_o !== 1'b0 || data_o !== 16'd0)
            $display("FAIL async_reset got=%0d/v%b want=0/v0", dout(), valid_o); else n_pass++;
        @(posedge clk_i);
        #1 reset_i = 1'b0;
        model_reset();
        for (int i = 0; i < R; i++) cycle(1, 3, 1, 0);
        n_checks++;
        if (dout() !== 3 || valid_o !== 1'b1)
            $display("FAIL reset_partial got=%0d/v%b want=3/v1", dout(), valid_o); else n_pass++;
        for (int i = 0; i < 4; i++) cycle(1, 50, 1, 0);
        cycle(1, 50, 1, 1);
        for (int i = 0; i < R; i++) cycle(1, 3, 1, 0);
        n_checks++;
        if (dout() !== 3 || valid_o !== 1'b1)
            $display("FAIL clear_partial got=%0d/v%b want=3/v1", dout(), valid_o); else n_pass++;
        cycle(0, 0, 1, 0);
    endtask

    task automatic test_random();
        logic [15:0] raw;
        bit v, r, c;
        for (int i = 0; i < 600; i++) begin
            raw = 16'($urandom);
            v   = ($urandom_range(0, 9) < 7);
            r   = $urandom_range(0, 1) == 1;
            c   = ($urandom_range(0, 99) < 3);
            cycle(v, int'($signed(raw)), r, c);
            n_checks++;
            if (valid_o !== exp_valid) $display("FAIL rnd_valid i=%0d got=%b want=%b", i, valid_o, exp_valid); else n_pass++;
            n_checks++;
            if (dout() !== exp_data) $display("FAIL rnd_data i=%0d got=%0d want=%0d", i, dout(), exp_data); else n_pass++;
            n_checks++;
            if (overrun_o !== exp_ovr) $display("FAIL rnd_ovr i=%0d got=%b want=%b", i, overrun_o, exp_ovr); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_rounding();
        test_full_scale();
        test_gaps();
        test_overrun();
        test_back_to_back();
        test_reset_mid_block();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
